// File: rtl/sync_counter_n.sv
// sync_counter_n: parametrised synchronous up/down counter with CI/CO cascade.
//
// Optional build macro: SYNCNT_MATCH_EN (registered compare match on MATCH).
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   RESET_VAL  value loaded into Q on asynchronous reset
//
// Ports:
//   MasterClock  in   system clock, rising edge active
//   RESETL       in   asynchronous reset, active low
//   D            in   load value, also captured as the reload value
//   CLR          in   synchronous clear, active high (beats load)
//   LDL          in   synchronous load, active low
//   CI           in   count enable / carry-in
//   UP           in   direction: 1 = up, 0 = down
//   MODE         in   00/11 free-run wrap, 01 one-shot, 10 auto-reload
//   CMP          in   compare value (used only with SYNCNT_MATCH_EN)
//   Q            out  counter value
//   QB           out  bitwise inverse of Q
//   CO           out  combinational carry-out (CI & terminal & not halted)
//   TC           out  registered one-cycle terminal-count pulse
//   DONE         out  one-shot halted flag
//   MATCH        out  registered compare match (0 when feature disabled)
module sync_counter_n #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR,
  input  logic             LDL,
  input  logic             CI,
  input  logic             UP,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] CMP,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             CO,
  output logic             TC,
  output logic             DONE,
  output logic             MATCH
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_RELOAD   = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] rld, rld_next;
  logic             tc, tc_next;
  logic             done, done_next;
  logic             term;

  // Terminal value depends on the direction currently applied.
  assign term = UP ? (q == '1) : (q == '0);

  always_comb begin
    q_next    = q;
    rld_next  = rld;
    done_next = done;
    tc_next   = 1'b0;
    if (CLR) begin
      q_next    = '0;
      done_next = 1'b0;
    end else if (!LDL) begin
      q_next    = D;
      rld_next  = D;
      done_next = 1'b0;
    end else if (CI && !done) begin
      if (!term) begin
        q_next = UP ? q + 1'b1 : q - 1'b1;
      end else begin
        tc_next = 1'b1;
        case (mode_t'(MODE))
          MODE_ONESHOT: done_next = 1'b1;
          MODE_RELOAD:  q_next    = rld;
          default:      q_next    = UP ? '0 : '1;
        endcase
      end
    end
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      q    <= RESET_VAL;
      rld  <= '0;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_next;
      rld  <= rld_next;
      tc   <= tc_next;
      done <= done_next;
    end
  end

`ifdef SYNCNT_MATCH_EN
  logic match;

  // Compared against the next value so MATCH lines up with Q == CMP.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      match <= 1'b0;
    end else begin
      match <= (q_next == CMP);
    end
  end

  assign MATCH = match;
`else
  logic unused_cmp;
  assign unused_cmp = ^CMP;
  assign MATCH      = 1'b0;
`endif

  assign Q    = q;
  assign QB   = ~q;
  assign CO   = CI & term & ~done;
  assign TC   = tc;
  assign DONE = done;

endmodule

// File: tb/tb_sync_counter_n.sv
// tb_sync_counter_n: directed scoreboard bench for sync_counter_n (WIDTH=4).
// Stimulus pushes hand-computed expectations; a monitor pops and compares
// one entry after every rising edge (or immediately for an async reset).
module tb_sync_counter_n;

  logic       clk;
  logic       rst_n;
  logic [3:0] d;
  logic       clr;
  logic       ldl;
  logic       ci;
  logic       up;
  logic [1:0] mode;
  logic [3:0] cmp;
  logic [3:0] q;
  logic [3:0] qb;
  logic       co;
  logic       tc;
  logic       done;
  logic       match;

  sync_counter_n #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
    .MasterClock(clk),
    .RESETL     (rst_n),
    .D          (d),
    .CLR        (clr),
    .LDL        (ldl),
    .CI         (ci),
    .UP         (up),
    .MODE       (mode),
    .CMP        (cmp),
    .Q          (q),
    .QB         (qb),
    .CO         (co),
    .TC         (tc),
    .DONE       (done),
    .MATCH      (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] q;
    logic       tc;
    logic       done;
    logic       co;
    logic       match;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h at %0t", nm, fld, act, req, $time);
    end
  endtask

  task automatic push(input string nm, input int q_e, input int tc_e, input int done_e, input int co_e);
    exp_t e;
    e.nm   = nm;
    e.q    = 4'(q_e);
    e.tc   = tc_e[0];
    e.done = done_e[0];
    e.co   = co_e[0];
`ifdef SYNCNT_MATCH_EN
    e.match = (e.q == 4'd6);
`else
    e.match = 1'b0;
`endif
    sb.push_back(e);
  endtask

  // Called at a falling edge: drive inputs, record the state expected after
  // the coming rising edge, then advance to the next falling edge.
  task automatic step(input string nm, input int clr_i, input int ldl_i, input int ci_i,
                      input int up_i, input int mode_i, input int d_i,
                      input int q_e, input int tc_e, input int done_e, input int co_e);
    clr  = clr_i[0];
    ldl  = ldl_i[0];
    ci   = ci_i[0];
    up   = up_i[0];
    mode = 2'(mode_i);
    d    = 4'(d_i);
    push(nm, q_e, tc_e, done_e, co_e);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.nm, "Q",     q,           e.q);
        chk(e.nm, "QB",    qb,          ~e.q);
        chk(e.nm, "TC",    {3'b0, tc},    {3'b0, e.tc});
        chk(e.nm, "DONE",  {3'b0, done},  {3'b0, e.done});
        chk(e.nm, "CO",    {3'b0, co},    {3'b0, e.co});
        chk(e.nm, "MATCH", {3'b0, match}, {3'b0, e.match});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    ldl   = 1'b1;
    ci    = 1'b0;
    up    = 1'b1;
    mode  = 2'b00;
    d     = 4'd0;
    cmp   = 4'd6;

    @(negedge clk);
    push("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count to 5, then async reset between edges
    for (int i = 1; i <= 5; i++) step("count", 0, 1, 1, 1, 0, 0, i, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    push("rst_mid", 0, 0, 0, 0);
    ->sample_ev;
    @(negedge clk);
    rst_n = 1'b1;
    step("resume1", 0, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    step("resume2", 0, 1, 1, 1, 0, 0, 2, 0, 0, 0);

    // Free-run wrap up from 14
    step("ld14",    0, 0, 0, 1, 0, 14, 14, 0, 0, 0);
    step("wrap15",  0, 1, 1, 1, 0, 0,  15, 0, 0, 1);
    step("wrap0",   0, 1, 1, 1, 0, 0,  0,  1, 0, 0);
    step("wrap1",   0, 1, 1, 1, 0, 0,  1,  0, 0, 0);

    // One-shot down from 3
    step("ld3",     0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
    step("os2",     0, 1, 1, 0, 1, 0, 2, 0, 0, 0);
    step("os1",     0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    step("os0",     0, 1, 1, 0, 1, 0, 0, 0, 0, 1);
    step("os_term", 0, 1, 1, 0, 1, 0, 0, 1, 1, 0);
    step("os_hold", 0, 1, 1, 0, 1, 0, 0, 0, 1, 0);
    step("os_mode", 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    step("os_ld7",  0, 0, 1, 0, 1, 7, 7, 0, 0, 0);

    // Auto-reload up from 12
    step("ld12",    0, 0, 0, 1, 2, 12, 12, 0, 0, 0);
    step("ar13",    0, 1, 1, 1, 2, 0,  13, 0, 0, 0);
    step("ar14",    0, 1, 1, 1, 2, 0,  14, 0, 0, 0);
    step("ar15",    0, 1, 1, 1, 2, 0,  15, 0, 0, 1);
    step("ar12",    0, 1, 1, 1, 2, 0,  12, 1, 0, 0);
    step("ar13b",   0, 1, 1, 1, 2, 0,  13, 0, 0, 0);

    // Clear beats load; reload register keeps 12
    step("clr_ld",  1, 0, 1, 1, 2, 9, 0,  0, 0, 0);
    step("hold",    0, 1, 0, 0, 2, 0, 0,  0, 0, 0);
    step("reload",  0, 1, 1, 0, 2, 0, 12, 1, 0, 0);
    step("hold12",  0, 1, 0, 0, 2, 0, 12, 0, 0, 0);

    // Match sweep with CMP=6
    step("m_clr",   1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) step("m_cnt", 0, 1, 1, 1, 0, 0, i, 0, 0, 0);

    ci = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_counter_n.md
Name: sync_counter_n

Overview:
- Parametrised synchronous up/down counter, WIDTH bits wide. It is the next generation of the single-bit synchronous load/clear counter stage.
- Adds the following over that stage:
  - direction control
  - three terminal-count modes: free-run wrap, one-shot halt, auto-reload
  - a registered terminal-count pulse
  - a halted flag
  - an optional compare match
- Used for video line/pixel timing, DSP loop counts and blitter step counters in place of chains of single-bit stages.
- Keeps the CI/CO cascade semantics, so wider counters can still be chained.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- RESET_VAL, 0, value loaded into Q on asynchronous reset.

Ports:
- MasterClock  in  1  system clock; all state changes on rising edge.
- RESETL  in  1  asynchronous reset, active low.
- D  in  WIDTH  load value; also captured as the reload value.
- CLR  in  1  synchronous clear, active high.
- LDL  in  1  synchronous load, active low.
- CI  in  1  count enable / carry-in, active high.
- UP  in  1  direction: 1 = up, 0 = down.
- MODE  in  2  00 free-run; 01 one-shot; 10 auto-reload; 11 treated as 00.
- CMP  in  WIDTH  compare value (used only with SYNCNT_MATCH_EN).
- Q  out  WIDTH  counter value.
- QB  out  WIDTH  bitwise inverse of Q.
- CO  out  1  combinational carry-out for cascading.
- TC  out  1  registered one-cycle terminal-count pulse.
- DONE  out  1  one-shot halted flag.
- MATCH  out  1  registered compare match.

Behaviour:
- Reset (RESETL low, asynchronous):
  - Q = RESET_VAL, reload register RLD = 0.
  - TC = 0, DONE = 0, MATCH = 0.
  - Reset takes effect immediately, including mid-count. Release is synchronous to the next edge.
- Terminal condition TERM:
  - UP=1: Q == all ones.
  - UP=0: Q == 0.
- Per-edge priority, highest first:
  1. CLR=1: Q <= 0; DONE <= 0; TC <= 0. RLD unchanged.
  2. LDL=0: Q <= D; RLD <= D; DONE <= 0; TC <= 0.
  3. CI=1 and DONE=0:
     - If TERM=0: Q <= Q+1 (UP=1) or Q-1 (UP=0). TC <= 0.
     - If TERM=1, by MODE:
       - 00/11: wrap. Q becomes 0 (up) or all ones (down). TC <= 1.
       - 01: Q holds. DONE <= 1. TC <= 1.
       - 10: Q <= RLD. TC <= 1.
  4. Otherwise: Q holds; TC <= 0.
- TC is high for exactly one cycle after each terminal step. Continuous counting through repeated terminals gives one pulse per terminal step.
- DONE, once set, blocks counting; CI is then ignored. Only CLR, load or reset clears it.
- A MODE change while DONE=1 does not clear DONE.
- CO = CI & TERM & ~DONE. It is purely combinational, with no register. This lets a higher stage's CI be the lower stage's CO.
- UP and MODE are sampled every edge. A change takes effect on the next edge, with no internal latching.
- CLR with LDL=0 in the same cycle: the clear wins and RLD is not written.
- All arithmetic is modulo 2^WIDTH. There is no saturation except one-shot hold.
- QB is always ~Q, including during reset.

Optional Feature:
- Macro SYNCNT_MATCH_EN.
- When defined:
  - MATCH <= (next Q == CMP) on each edge. MATCH therefore asserts in the same cycle that Q equals CMP.
  - Reset gives MATCH = 0.
  - CLR and load also evaluate against the new Q.
- When undefined:
  - MATCH is tied to 0.
  - CMP is unused and no compare logic is generated.
- Port list is identical in both builds.

Test Plan (WIDTH=4, RESET_VAL=0 unless stated):
- Reset mid-count: count to Q=5 with CI=1, pull RESETL low between edges -> Q=0, TC=0, DONE=0 immediately. After release, counting resumes from 0.
- Free-run wrap: MODE=00, UP=1, CI=1 from Q=14 -> Q goes 15, 0, 1. CO=1 only while Q=15. TC=1 only in the cycle Q=0.
- One-shot down: LDL=0 with D=3, then MODE=01, UP=0, CI=1 -> Q goes 2, 1, 0, 0, 0. DONE=1 from the cycle after Q first reaches 0. TC is a single pulse. CO=0 after DONE. LDL=0 with D=7 -> DONE=0, Q=7.
- Auto-reload: load D=12, MODE=10, UP=1, CI=1 -> Q goes 13, 14, 15, 12, 13. TC pulses in each cycle Q returns to 12.
- Priority: CLR=1 and LDL=0 with D=9 in the same cycle -> Q=0. A later reload in MODE=10 reloads the previous RLD, not 9. CI=0 holds Q.
- Match (SYNCNT_MATCH_EN defined): CMP=6, count up from 0 -> MATCH=1 in exactly the cycle Q=6. With the macro undefined, MATCH stays 0 throughout.
